// File: rtl/usbh_pad_arbiter_pkg.sv
// Shared types and widths for the two-port USB host pad arbiter.
// The round-robin pick helper is used by the top-level grant logic.
package usbh_pad_arbiter_pkg;

  localparam int REPORT_W = 64;
  localparam int BTN_W    = 12;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2
  } state_t;

  // rr names the preferred port; the other port wins only when rr's buffer is empty
  function automatic logic rr_pick(input logic [1:0] pend, input logic rr);
    return pend[rr] ? rr : ~rr;
  endfunction

endpackage

// File: rtl/usbh_pad_arbiter_port.sv
// Per-port holding buffer, pending flag, overrun pulse and inactivity timer.
// o_timeout is a combinational pulse the top uses to clear this port's buttons.
module usbh_pad_arbiter_port
  import usbh_pad_arbiter_pkg::*;
#(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd1_000_000
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [REPORT_W-1:0] i_report,
  input  logic                i_report_valid,
  input  logic                i_consume,
  output logic [REPORT_W-1:0] o_report,
  output logic                o_pend,
  output logic                o_overrun,
  output logic                o_active,
  output logic                o_timeout
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES - 24'd1);
  localparam logic [CNT_W-1:0] CNT_FIRE = CNT_W'(TIMEOUT_CYCLES - 24'd2);

  logic [CNT_W-1:0] cnt;

  // Fires on the edge where the counter reaches its saturation value
  assign o_timeout = !i_report_valid && (cnt == CNT_FIRE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_report  <= '0;
      o_pend    <= 1'b0;
      o_overrun <= 1'b0;
      o_active  <= 1'b0;
      cnt       <= '0;
    end else begin
      // A strobe racing the consume refills the buffer without counting as lost
      o_overrun <= i_report_valid && o_pend && !i_consume;
      if (i_report_valid) begin
        o_report <= i_report;
        o_pend   <= 1'b1;
      end else if (i_consume) begin
        o_pend <= 1'b0;
      end
      if (i_report_valid) begin
        cnt      <= '0;
        o_active <= 1'b1;
      end else begin
        if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
        if (o_timeout) o_active <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/usbh_pad_arbiter.sv
// Round-robin sharing of one external keypad report decoder between two host ports.
// Each decode runs IDLE (grant) -> ISSUE (decoder load) -> CAPTURE (button write-back).
module usbh_pad_arbiter
  import usbh_pad_arbiter_pkg::*;
#(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd1_000_000
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [REPORT_W-1:0] i_report0,
  input  logic                i_report0_valid,
  input  logic [REPORT_W-1:0] i_report1,
  input  logic                i_report1_valid,
  output logic [REPORT_W-1:0] o_dec_report,
  output logic                o_dec_report_valid,
  input  logic [BTN_W-1:0]    i_dec_btn,
  output logic [BTN_W-1:0]    o_btn0,
  output logic [BTN_W-1:0]    o_btn1,
  output logic [1:0]          o_active,
  output logic [1:0]          o_overrun,
  output state_t              o_dbg_state
);

  state_t              state;
  logic                rr;
  logic                gnt;
  logic [1:0]          pend;
  logic [1:0]          consume;
  logic [1:0]          timeout;
  logic [REPORT_W-1:0] held0;
  logic [REPORT_W-1:0] held1;
  logic                sel;

  assign sel         = rr_pick(pend, rr);
  assign consume     = ((state == ST_IDLE) && (|pend)) ? (sel ? 2'b10 : 2'b01) : 2'b00;
  assign o_dbg_state = state;

  usbh_pad_arbiter_port #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_port0 (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_report       (i_report0),
    .i_report_valid (i_report0_valid),
    .i_consume      (consume[0]),
    .o_report       (held0),
    .o_pend         (pend[0]),
    .o_overrun      (o_overrun[0]),
    .o_active       (o_active[0]),
    .o_timeout      (timeout[0])
  );

  usbh_pad_arbiter_port #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_port1 (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_report       (i_report1),
    .i_report_valid (i_report1_valid),
    .i_consume      (consume[1]),
    .o_report       (held1),
    .o_pend         (pend[1]),
    .o_overrun      (o_overrun[1]),
    .o_active       (o_active[1]),
    .o_timeout      (timeout[1])
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state              <= ST_IDLE;
      rr                 <= 1'b0;
      gnt                <= 1'b0;
      o_dec_report       <= '0;
      o_dec_report_valid <= 1'b0;
      o_btn0             <= '0;
      o_btn1             <= '0;
    end else begin
      if (timeout[0]) o_btn0 <= '0;
      if (timeout[1]) o_btn1 <= '0;
      case (state)
        ST_IDLE: begin
          if (|pend) begin
            o_dec_report       <= sel ? held1 : held0;
            o_dec_report_valid <= 1'b1;
            gnt                <= sel;
            rr                 <= ~sel;
            state              <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          o_dec_report_valid <= 1'b0;
          state              <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          // Assigned after the timeout clear so a coincident capture wins
          if (gnt) o_btn1 <= i_dec_btn;
          else     o_btn0 <= i_dec_btn;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usbh_pad_arbiter.sv
// Bench for usbh_pad_arbiter: a keypad decoder stand-in, a schedule-based reference
// model compared every cycle, plus directed scenarios with fixed expected values.
module tb_usbh_pad_arbiter;
  import usbh_pad_arbiter_pkg::*;

  localparam logic [23:0] TMO = 24'd16;
  localparam int          TI  = 16;

  logic        i_clk;
  logic        i_rst_n;
  logic [63:0] i_report0, i_report1;
  logic        i_report0_valid, i_report1_valid;
  logic [63:0] o_dec_report;
  logic        o_dec_report_valid;
  logic [11:0] i_dec_btn;
  logic [11:0] o_btn0, o_btn1;
  logic [1:0]  o_active, o_overrun;
  state_t      dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 0;
  int ovr0_cnt = 0;

  usbh_pad_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
    .i_clk              (i_clk),
    .i_rst_n            (i_rst_n),
    .i_report0          (i_report0),
    .i_report0_valid    (i_report0_valid),
    .i_report1          (i_report1),
    .i_report1_valid    (i_report1_valid),
    .o_dec_report       (o_dec_report),
    .o_dec_report_valid (o_dec_report_valid),
    .i_dec_btn          (i_dec_btn),
    .o_btn0             (o_btn0),
    .o_btn1             (o_btn1),
    .o_active           (o_active),
    .o_overrun          (o_overrun),
    .o_dbg_state        (dbg_state)
  );

  // ---------------- clock ----------------
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish, required finish before 400000");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- keypad decoder stand-in ----------------
  function automatic logic [11:0] key_bit(input logic [7:0] k);
    case (k)
      8'h5f, 8'h60: return 12'h001;
      8'h61:        return 12'h002;
      8'h5c:        return 12'h004;
      8'h5e:        return 12'h008;
      8'h5a:        return 12'h010;
      8'h5d:        return 12'h020;
      8'h59:        return 12'h040;
      8'h5b:        return 12'h080;
      8'h62:        return 12'h100;
      8'h57:        return 12'h200;
      8'h56:        return 12'h400;
      8'h58:        return 12'h800;
      default:      return 12'h000;
    endcase
  endfunction

  function automatic logic [11:0] decode(input logic [63:0] r);
    logic [11:0] b;
    b = '0;
    for (int i = 2; i < 8; i++) b |= key_bit(r[i*8 +: 8]);
    return b;
  endfunction

  function automatic logic [63:0] mk_rep(input logic [7:0] k);
    return {40'h0, k, 16'h0};
  endfunction

  function automatic logic [63:0] rand_rep();
    logic [63:0] r;
    logic [7:0]  tab [12];
    tab = '{8'h5f, 8'h60, 8'h61, 8'h5c, 8'h5e, 8'h5a, 8'h5d, 8'h59, 8'h5b, 8'h62, 8'h57, 8'h56};
    r = '0;
    r[15:0] = 16'($urandom);
    for (int i = 2; i < 8; i++)
      if ($urandom_range(0, 2) == 0) r[i*8 +: 8] = tab[$urandom_range(0, 11)];
    return r;
  endfunction

  // Decoder output is only meaningful the cycle after a load; otherwise noise
  initial begin
    logic        ld;
    logic [63:0] rep;
    i_dec_btn = '0;
    forever begin
      @(negedge i_clk);
      ld  = o_dec_report_valid;
      rep = o_dec_report;
      @(posedge i_clk);
      #1;
      i_dec_btn = ld ? decode(rep) : 12'($urandom);
    end
  end

  // ---------------- reference model ----------------
  // Each grant occupies the decoder for 3 cycles; its result lands 3 cycles after grant.
  int          cyc, free_at, cap_time, cap_port, m_rr;
  logic [11:0] cap_val;
  bit          m_pend [2];
  logic [63:0] m_buf  [2];
  int          last   [2];
  bit          ever   [2];
  logic [11:0] exp_btn [2];
  logic [1:0]  exp_active, exp_ovr;
  logic        exp_valid;
  logic [63:0] exp_rep;

  task automatic m_reset();
    free_at = 0; cap_time = -100; cap_port = 0; cap_val = '0; m_rr = 0;
    for (int p = 0; p < 2; p++) begin
      m_pend[p] = 0; m_buf[p] = '0; last[p] = -1000; ever[p] = 0; exp_btn[p] = '0;
    end
    exp_active = '0; exp_ovr = '0; exp_valid = 0; exp_rep = '0;
  endtask

  task automatic m_step();
    int          g;
    bit          stb [2];
    logic [63:0] rep [2];
    stb[0] = i_report0_valid; rep[0] = i_report0;
    stb[1] = i_report1_valid; rep[1] = i_report1;
    g = -1;
    if (cyc >= free_at && (m_pend[0] || m_pend[1])) g = m_pend[m_rr] ? m_rr : 1 - m_rr;
    for (int p = 0; p < 2; p++) exp_ovr[p] = stb[p] && m_pend[p] && (g != p);
    exp_valid = (g >= 0);
    if (cap_time == cyc + 1) exp_btn[cap_port] = cap_val;
    for (int p = 0; p < 2; p++)
      if (ever[p] && !stb[p] && (cyc + 1 == last[p] + TI) && !(cap_time == cyc + 1 && cap_port == p))
        exp_btn[p] = '0;
    if (g >= 0) begin
      exp_rep  = m_buf[g];
      cap_time = cyc + 3;
      cap_port = g;
      cap_val  = decode(m_buf[g]);
      free_at  = cyc + 3;
      m_pend[g] = 0;
      m_rr     = 1 - g;
    end
    for (int p = 0; p < 2; p++)
      if (stb[p]) begin
        m_buf[p] = rep[p]; m_pend[p] = 1; last[p] = cyc; ever[p] = 1;
      end
    for (int p = 0; p < 2; p++) exp_active[p] = ever[p] && ((cyc + 1 - last[p]) < TI);
    cyc++;
  endtask

  initial begin
    cyc = 0;
    m_reset();
    forever begin
      @(posedge i_clk or negedge i_rst_n);
      if (!i_rst_n) m_reset();
      else m_step();
    end
  end

  // Scoreboard compare, away from the active edge
  initial begin
    forever begin
      @(negedge i_clk);
      if (i_rst_n && chk_en) begin
        check_eq("btn0", o_btn0, exp_btn[0]);
        check_eq("btn1", o_btn1, exp_btn[1]);
        check_eq("active", o_active, exp_active);
        check_eq("overrun", o_overrun, exp_ovr);
        check_eq("dec_valid", o_dec_report_valid, exp_valid);
        check_eq("dec_report", o_dec_report, exp_rep);
        if (o_overrun[0]) ovr0_cnt++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic strobe(input logic v0, input logic [63:0] r0, input logic v1, input logic [63:0] r1);
    @(posedge i_clk); #1;
    i_report0_valid = v0; if (v0) i_report0 = r0;
    i_report1_valid = v1; if (v1) i_report1 = r1;
    @(posedge i_clk); #1;
    i_report0_valid = 0; i_report1_valid = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic at_cycle(input int n);
    repeat (n) @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_btn0"}, o_btn0, 12'h0);
    check_eq({tag, "_btn1"}, o_btn1, 12'h0);
    check_eq({tag, "_active"}, o_active, 2'b00);
    check_eq({tag, "_overrun"}, o_overrun, 2'b00);
    check_eq({tag, "_dec_report"}, o_dec_report, 64'h0);
    check_eq({tag, "_dec_valid"}, o_dec_report_valid, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base;
    i_rst_n = 0;
    i_report0 = '0; i_report1 = '0;
    i_report0_valid = 0; i_report1_valid = 0;
    repeat (2) @(posedge i_clk);
    #1;
    check_all_zero("por");
    i_rst_n = 1;
    chk_en  = 1;

    // warm-up so reset has something to clear
    strobe(1, mk_rep(8'h5a), 0, '0);
    at_cycle(3);
    check_eq("warm_btn0", o_btn0, 12'h010);
    idle(6);

    // asynchronous reset landing in ISSUE
    strobe(1, mk_rep(8'h5f), 0, '0);
    @(posedge i_clk); #3;
    i_rst_n = 0;
    #1;
    check_all_zero("rst_issue");
    idle(2);
    i_rst_n = 1;

    strobe(1, mk_rep(8'h60), 0, '0);
    at_cycle(2);
    check_eq("post_rst_t3", o_btn0, 12'h000);
    at_cycle(1);
    check_eq("post_rst_t4", o_btn0, 12'h001);
    idle(8);

    // port 1 alone leaves rr pointing at port 0
    strobe(0, '0, 1, mk_rep(8'h62));
    idle(8);
    strobe(1, mk_rep(8'h5c), 1, mk_rep(8'h5e));
    at_cycle(3);
    check_eq("sim_a_btn0", o_btn0, 12'h004);
    at_cycle(3);
    check_eq("sim_a_btn1", o_btn1, 12'h008);
    idle(8);

    // a lone port-0 decode moves preference to port 1
    strobe(1, mk_rep(8'h59), 0, '0);
    idle(8);
    strobe(1, mk_rep(8'h5a), 1, mk_rep(8'h5d));
    at_cycle(3);
    check_eq("sim_b_btn1", o_btn1, 12'h020);
    at_cycle(3);
    check_eq("sim_b_btn0", o_btn0, 12'h010);
    idle(10);

    // overrun while port 1 is being decoded
    strobe(0, '0, 1, mk_rep(8'h62));
    base = ovr0_cnt;
    i_report0_valid = 1; i_report0 = mk_rep(8'h61);
    @(posedge i_clk); #1;
    i_report0 = mk_rep(8'h5f);
    @(posedge i_clk); #1;
    i_report0_valid = 0;
    at_cycle(4);
    check_eq("ovr_btn0", o_btn0, 12'h001);
    check_eq("ovr_pulses", 32'(ovr0_cnt - base), 32'd1);
    idle(10);

    // strobe coincident with the grant that consumes the buffer
    base = ovr0_cnt;
    strobe(1, mk_rep(8'h5a), 0, '0);
    i_report0_valid = 1; i_report0 = mk_rep(8'h5d);
    @(posedge i_clk); #1;
    i_report0_valid = 0;
    at_cycle(2);
    check_eq("coin_first", o_btn0, 12'h010);
    at_cycle(3);
    check_eq("coin_second", o_btn0, 12'h020);
    check_eq("coin_no_ovr", 32'(ovr0_cnt - base), 32'd0);
    idle(20);

    // timeout on port 1 while port 0 keeps reporting
    @(posedge i_clk); #1;
    i_report1_valid = 1; i_report1 = mk_rep(8'h5c);
    for (int k = 1; k <= TI; k++) begin
      @(posedge i_clk); #1;
      i_report1_valid = 0;
      i_report0_valid = (k == 6 || k == 12);
      i_report0 = mk_rep(8'h5b);
      if (k == TI - 1) begin
        @(negedge i_clk);
        check_eq("tmo_pre_btn1", o_btn1, 12'h004);
        check_eq("tmo_pre_act1", o_active[1], 1'b1);
      end
      if (k == TI) begin
        @(negedge i_clk);
        check_eq("tmo_btn1", o_btn1, 12'h000);
        check_eq("tmo_act1", o_active[1], 1'b0);
        check_eq("tmo_act0", o_active[0], 1'b1);
        check_eq("tmo_btn0", o_btn0, 12'h080);
      end
    end
    @(posedge i_clk); #1;
    i_report0_valid = 0;
    idle(20);

    // randomized bursts separated by silence long enough to time out
    for (int blk = 0; blk < 12; blk++) begin
      int p;
      p = $urandom_range(1, 5);
      for (int k = 0; k < 40; k++) begin
        @(posedge i_clk); #1;
        i_report0_valid = ($urandom_range(0, p) == 0);
        i_report0       = rand_rep();
        i_report1_valid = ($urandom_range(0, p) == 0);
        i_report1       = rand_rep();
      end
      @(posedge i_clk); #1;
      i_report0_valid = 0; i_report1_valid = 0;
      idle($urandom_range(4, 24));
    end
    idle(20);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
